// File: rtl/adc_code_averager.sv
// adc_code_averager
//   Consumes the asynchronous 2-bit code from the flash-ADC thermometer encoder.
//   Resynchronises it, takes one sample every DECIM clocks while converting,
//   and averages 2^LOG2_SAMPLES samples per window. Each window result is
//   presented on a registered output together with a one-cycle valid strobe.
//   Windows can run back-to-back (continuous=1), or a single window can be
//   taken per enable assertion (continuous=0).
//
// Optional build macro: ADC_AVG_ROUND_EN
//   undefined : average = window_sum >> LOG2_SAMPLES (truncate)
//   defined   : average = (window_sum + half) >> LOG2_SAMPLES, saturated to max code
//
// Ports
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   enable      run conversion while high; low aborts and returns to idle
//   continuous  1 = back-to-back windows, 0 = one window per enable assertion
//   code_in     encoded ADC code, asynchronous to clk
//   avg_out     registered window average, holds between updates
//   avg_valid   one-cycle pulse when avg_out updates
//   busy        high while accumulating
//
// States
//   IDLE  | waiting for enable; divider, counter and accumulator held clear
//   ACCUM | sampling one code per tick and summing the window
//   DONE  | single-shot window finished; waiting for enable to drop
module adc_code_averager #(
  parameter int CODE_W       = 2,
  parameter int LOG2_SAMPLES = 3,
  parameter int DECIM        = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              continuous,
  input  logic [CODE_W-1:0] code_in,
  output logic [CODE_W-1:0] avg_out,
  output logic              avg_valid,
  output logic              busy
);

  // One bit above the worst-case window sum, so a rounded sum cannot wrap
  // before it is saturated.
  localparam int ACC_W = CODE_W + LOG2_SAMPLES + 1;
  localparam int DIV_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DECIM - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  state;
  logic [CODE_W-1:0]       sync1;
  logic [CODE_W-1:0]       code_s;
  logic [DIV_W-1:0]        div;
  logic [LOG2_SAMPLES-1:0] scnt;
  logic [ACC_W-1:0]        acc;

  logic                    tick;
  logic                    last_sample;
  logic [ACC_W-1:0]        sum;
  logic [CODE_W-1:0]       avg_next;

`ifdef ADC_AVG_ROUND_EN
  localparam int               HALF     = 1 << (LOG2_SAMPLES - 1);
  localparam logic [CODE_W-1:0] MAX_CODE = '1;
  logic [ACC_W-1:0] rsum;
  logic [ACC_W-1:0] quot;
`endif

  always_comb begin
    tick        = (state == ACCUM) && (div == DIV_LAST);
    last_sample = (scnt == '1);
    sum         = acc + ACC_W'(code_s);
`ifdef ADC_AVG_ROUND_EN
    rsum     = sum + ACC_W'(HALF);
    quot     = rsum >> LOG2_SAMPLES;
    avg_next = (quot > ACC_W'(MAX_CODE)) ? MAX_CODE : CODE_W'(quot);
`else
    // The window sum of CODE_W-bit samples always fits in CODE_W bits after
    // the shift, so plain truncation needs no clamp.
    avg_next = CODE_W'(sum >> LOG2_SAMPLES);
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1     <= '0;
      code_s    <= '0;
      state     <= IDLE;
      div       <= '0;
      scnt      <= '0;
      acc       <= '0;
      avg_out   <= '0;
      avg_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      sync1     <= code_in;
      code_s    <= sync1;
      avg_valid <= 1'b0;

      case (state)
        IDLE: begin
          div  <= '0;
          scnt <= '0;
          acc  <= '0;
          if (enable) begin
            state <= ACCUM;
            busy  <= 1'b1;
          end
        end

        ACCUM: begin
          if (!enable) begin
            // Abort wins over a coincident final tick: result is discarded.
            state <= IDLE;
            busy  <= 1'b0;
            div   <= '0;
            scnt  <= '0;
            acc   <= '0;
          end else begin
            div <= tick ? '0 : div + DIV_W'(1);
            if (tick) begin
              if (last_sample) begin
                avg_out   <= avg_next;
                avg_valid <= 1'b1;
                acc       <= '0;
                scnt      <= '0;
                if (!continuous) begin
                  state <= DONE;
                  busy  <= 1'b0;
                end
              end else begin
                acc  <= sum;
                scnt <= scnt + LOG2_SAMPLES'(1);
              end
            end
          end
        end

        DONE: begin
          if (!enable) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_code_averager.sv
// Scoreboard bench for adc_code_averager (default parameters).
// code_in is driven from a repeating 8-entry pattern, one entry per 4-clock
// block. Since sample ticks are also 4 clocks apart, every window sees each
// pattern entry exactly once, so the window sum is the pattern sum
// regardless of phase alignment.
module tb_adc_code_averager;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       continuous = 1'b0;
  logic [1:0] code_in = 2'd0;
  logic [1:0] avg_out;
  logic       avg_valid;
  logic       busy;

  adc_code_averager dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .continuous (continuous),
    .code_in    (code_in),
    .avg_out    (avg_out),
    .avg_valid  (avg_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int avg;
    int cyc;
  } exp_t;

  exp_t  exp_q[$];
  int    cyc = 0;
  int    n_total = 0;
  int    n_pass = 0;
  int    valid_seen = 0;
  logic  prev_valid = 1'b0;
  logic [15:0] pat_word = 16'h0000;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    int idx;
    idx = (cyc / 4) % 8;
    code_in = pat_word[2*idx +: 2];
  end

  task automatic check(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // Monitor: pops one expectation per avg_valid pulse.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (avg_valid) begin
        valid_seen++;
        check("valid_width", int'(prev_valid), 0);
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_valid: avg_out %0d at cycle %0d, none expected", avg_out, cyc);
        end else begin
          e = exp_q.pop_front();
          check("avg_out", int'(avg_out), e.avg);
          check("valid_cycle", cyc, e.cyc);
        end
      end
      prev_valid = avg_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic push(input int avg, input int at_cyc);
    exp_t e;
    e.avg = avg;
    e.cyc = at_cyc;
    exp_q.push_back(e);
  endtask

  // One single-shot window with a given pattern and expected average.
  task automatic run_single(input logic [15:0] pat, input int exp_avg);
    int c0;
    pat_word = pat;
    continuous = 1'b0;
    repeat (4) @(negedge clk);
    enable = 1'b1;
    c0 = cyc;
    push(exp_avg, c0 + 33);
    repeat (32) @(negedge clk);
    check("busy_before_final", int'(busy), 1);
    @(negedge clk);
    check("busy_after_final", int'(busy), 0);
    repeat (5) @(negedge clk);
    enable = 1'b0;
    repeat (2) @(negedge clk);
  endtask

`ifdef ADC_AVG_ROUND_EN
  localparam int EXP_ALT12 = 2;
  localparam int EXP_SUM17 = 2;
  localparam int EXP_SUM7  = 1;
`else
  localparam int EXP_ALT12 = 1;
  localparam int EXP_SUM17 = 2;
  localparam int EXP_SUM7  = 0;
`endif

  initial begin
    int c0;
    int vs0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_avg_out", int'(avg_out), 0);
    check("rst_avg_valid", int'(avg_valid), 0);
    check("rst_busy", int'(busy), 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy", int'(busy), 0);

    // Continuous, constant 2: three windows 32 cycles apart, first at +33
    pat_word = 16'hAAAA;
    continuous = 1'b1;
    repeat (4) @(negedge clk);
    enable = 1'b1;
    c0 = cyc;
    push(2, c0 + 33);
    push(2, c0 + 65);
    push(2, c0 + 97);
    @(negedge clk);
    check("busy_enter", int'(busy), 1);
    repeat (96) @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_stop", int'(busy), 0);

    // Pattern windows
    run_single(16'h9999, EXP_ALT12);  // 1,2 alternating, sum 12
    run_single(16'hB37B, EXP_SUM17);  // 3,2,3,1,3,0,3,2, sum 17
    run_single(16'h1555, EXP_SUM7);   // seven 1s and a 0, sum 7
    run_single(16'hFFFF, 3);          // all max
    run_single(16'h0000, 0);          // all zero

    // Single-shot with enable held 100 cycles: exactly one pulse
    pat_word = 16'hAAAA;
    continuous = 1'b0;
    repeat (4) @(negedge clk);
    vs0 = valid_seen;
    enable = 1'b1;
    c0 = cyc;
    push(2, c0 + 33);
    repeat (50) @(negedge clk);
    check("done_busy", int'(busy), 0);
    pat_word = 16'hFFFF;
    repeat (50) @(negedge clk);
    check("single_pulse_count", valid_seen - vs0, 1);
    check("done_hold_busy", int'(busy), 0);
    enable = 1'b0;
    @(negedge clk);
    check("done_exit_busy", int'(busy), 0);

    // Abort coincident with the 8th tick: avg_out keeps 2, no pulse
    enable = 1'b1;
    c0 = cyc;
    @(negedge clk);
    check("reenable_busy", int'(busy), 1);
    repeat (31) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("abort_busy", int'(busy), 0);
    check("abort_avg_out", int'(avg_out), 2);
    check("abort_no_valid", int'(avg_valid), 0);

    // Fresh window after abort: all 1s must give 1, not stale sum
    pat_word = 16'h5555;
    repeat (4) @(negedge clk);
    enable = 1'b1;
    c0 = cyc;
    push(1, c0 + 33);
    repeat (40) @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);

    // Reset mid-window (after five ticks), then a fresh full window
    pat_word = 16'hFFFF;
    repeat (4) @(negedge clk);
    enable = 1'b1;
    repeat (24) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_avg_out", int'(avg_out), 0);
    check("midrst_avg_valid", int'(avg_valid), 0);
    check("midrst_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    c0 = cyc;
    push(3, c0 + 33);
    repeat (40) @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);

    check("pending_expectations", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
